nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 167 ++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial adder with valid/ready handshake
// One shared 4-bit ripple-carry slice is reused once per nibble, low nibble first.

module nsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nsa_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    nsa_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Carry into bit 3 is what overflow detection needs on the top slice.
  assign c3 = c[3];
  assign co = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic            msb_cin_q, msb_cin_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      slice_a, slice_b, slice_s;
  logic            slice_c3, slice_co;

  assign slice_a = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b = b_q[{idx_q, 2'b00} +: 4];

  nsa_rca4 u_rca4 (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .co (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d   = slice_co;
        msb_cin_d = slice_c3;
        if (idx_q == LAST_IDX) begin
          // Final carry leaves through cout only; slice 0 is never revisited.
          cout_d  = slice_co;
          ovf_d   = slice_c3 ^ slice_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed checks of nibble_serial_add_ctrl at NIBBLES=4

module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one pair, scramble the inputs, and check out_valid appears on exactly the 4th edge.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".ov_edge0"}, out_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.ov_edge%0d", tag, i), out_valid, (i == 4) ? 1 : 0);
    end
    chk({tag, ".sum"}, sum, exp_sum);
    chk({tag, ".cout"}, cout, exp_cout);
    chk({tag, ".ovf"}, ovf, exp_ovf);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, ".in_ready_done"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    chk({tag, ".out_valid_idle"}, out_valid, 0);
    chk({tag, ".busy_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.sum", sum, 16'h0000);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("v1234", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    finish_op("v1234");
    run_op("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    finish_op("vffff");
    run_op("vcin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    finish_op("vcin");
    run_op("v7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    finish_op("v7fff");
    run_op("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Stall in DONE with a competing request and wiggling operands.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = i[0];
      @(posedge clk); #1;
      chk($sformatf("stall%0d.sum", i), sum, 16'h0000);
      chk($sformatf("stall%0d.out_valid", i), out_valid, 1);
      chk($sformatf("stall%0d.in_ready", i), in_ready, 0);
      chk($sformatf("stall%0d.cout", i), cout, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op("stall");
    repeat (2) @(posedge clk);
    #1;
    chk("idle_hold.sum", sum, 16'h0000);
    chk("idle_hold.ovf", ovf, 1);
    chk("idle_hold.busy", busy, 0);

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst.in_ready", in_ready, 1);
    chk("arst.out_valid", out_valid, 0);
    chk("arst.busy", busy, 0);
    chk("arst.sum", sum, 16'h0000);
    chk("arst.cout", cout, 0);
    chk("arst.ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    finish_op("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
